// File: rtl/stream_rsp_router_if.sv
// Request/response handshake bundle between the arbiter, downstream and requesters.
// slave: router side; master: environment side.
interface stream_rsp_router_if #(
  parameter int NumInp    = 4,
  parameter int MaxTxn    = 8,
  parameter int DataWidth = 32
);
  localparam int IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int CntW = $clog2(MaxTxn + 1);

  logic                 req_valid_i;
  logic [IdxW-1:0]      req_idx_i;
  logic                 req_ready_o;
  logic                 req_valid_o;
  logic                 req_ready_i;
  logic                 rsp_valid_i;
  logic [DataWidth-1:0] rsp_data_i;
  logic                 rsp_ready_o;
  logic [NumInp-1:0]    rsp_valid_o;
  logic [DataWidth-1:0] rsp_data_o;
  logic [NumInp-1:0]    rsp_ready_i;
  logic [CntW-1:0]      outstanding_o;
  logic                 full_o;
  logic                 empty_o;

  modport slave (
    input  req_valid_i, req_idx_i, req_ready_i,
    input  rsp_valid_i, rsp_data_i, rsp_ready_i,
    output req_ready_o, req_valid_o, rsp_ready_o,
    output rsp_valid_o, rsp_data_o,
    output outstanding_o, full_o, empty_o
  );

  modport master (
    output req_valid_i, req_idx_i, req_ready_i,
    output rsp_valid_i, rsp_data_i, rsp_ready_i,
    input  req_ready_o, req_valid_o, rsp_ready_o,
    input  rsp_valid_o, rsp_data_o,
    input  outstanding_o, full_o, empty_o
  );
endinterface

// File: rtl/stream_rsp_router.sv
// Routes in-order response beats back to the requester that won arbitration,
// using a FIFO of granted input indices.
module stream_rsp_router #(
  parameter int NumInp    = 4,
  parameter int MaxTxn    = 8,
  parameter int DataWidth = 32
) (
  input logic                clk_i,
  input logic                rst_i,
  stream_rsp_router_if.slave bus
);
  localparam int IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int CntW = $clog2(MaxTxn + 1);
  localparam int PtrW = (MaxTxn > 1) ? $clog2(MaxTxn) : 1;

  logic [IdxW-1:0] mem_q [MaxTxn];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            full, empty;
  logic            push, pop, rsp_rdy;
  logic [IdxW-1:0] head;
  logic [NumInp-1:0] rsp_vld;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTxn - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    full    = (cnt_q == CntW'(MaxTxn));
    empty   = (cnt_q == '0);
    head    = mem_q[rd_ptr_q];
    push    = bus.req_valid_i & bus.req_ready_i & ~full;
    rsp_rdy = ~empty & bus.rsp_ready_i[head];
    pop     = bus.rsp_valid_i & rsp_rdy;
    rsp_vld = '0;
    if (bus.rsp_valid_i && !empty) rsp_vld[head] = 1'b1;
    wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? nxt(rd_ptr_q) : rd_ptr_q;
    unique case (1'b1)
      push & ~pop: cnt_d = cnt_q + CntW'(1);
      pop & ~push: cnt_d = cnt_q - CntW'(1);
      default:     cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= bus.req_idx_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.req_valid_o   = bus.req_valid_i & ~full;
  assign bus.req_ready_o   = bus.req_ready_i & ~full;
  assign bus.rsp_ready_o   = rsp_rdy;
  assign bus.rsp_valid_o   = rsp_vld;
  assign bus.rsp_data_o    = DataWidth'(bus.rsp_data_i);
  assign bus.outstanding_o = cnt_q;
  assign bus.full_o        = full;
  assign bus.empty_o       = empty;

  a_no_pop_empty: assert property (
    @(posedge clk_i) disable iff (rst_i) !(pop && empty));
  a_no_push_full: assert property (
    @(posedge clk_i) disable iff (rst_i) !(push && full));
  a_onehot0: assert property (
    @(posedge clk_i) disable iff (rst_i) $onehot0(rsp_vld));

  // Only needed when the index field can encode non-existent inputs.
  if (NumInp < (1 << IdxW)) begin : g_idx_chk
    a_idx_legal: assert property (
      @(posedge clk_i) disable iff (rst_i)
      push |-> (int'(bus.req_idx_i) < NumInp));
  end
endmodule

// File: tb/tb_stream_rsp_router.sv
// Randomized and directed bench: two routers (depth 8 and 5) share stimulus,
// each checked against a queue-based reference model.
module tb_stream_rsp_router;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid;
  logic [1:0]  req_idx;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_ready;

  int nchecks = 0;
  int nerrs   = 0;
  int npops   = 0;
  bit model_ok = 1'b0;
  int q8[$];
  int q5[$];

  always #5 clk = ~clk;

  stream_rsp_router_if #(.NumInp(4), .MaxTxn(8), .DataWidth(32)) if8 ();
  stream_rsp_router_if #(.NumInp(4), .MaxTxn(5), .DataWidth(32)) if5 ();

  assign if8.req_valid_i = req_valid;
  assign if8.req_idx_i   = req_idx;
  assign if8.req_ready_i = req_ready;
  assign if8.rsp_valid_i = rsp_valid;
  assign if8.rsp_data_i  = rsp_data;
  assign if8.rsp_ready_i = rsp_ready;
  assign if5.req_valid_i = req_valid;
  assign if5.req_idx_i   = req_idx;
  assign if5.req_ready_i = req_ready;
  assign if5.rsp_valid_i = rsp_valid;
  assign if5.rsp_data_i  = rsp_data;
  assign if5.rsp_ready_i = rsp_ready;

  stream_rsp_router #(.NumInp(4), .MaxTxn(8), .DataWidth(32)) dut8 (
    .clk_i(clk), .rst_i(rst), .bus(if8.slave));
  stream_rsp_router #(.NumInp(4), .MaxTxn(5), .DataWidth(32)) dut5 (
    .clk_i(clk), .rst_i(rst), .bus(if5.slave));

  task automatic chk(input string nm, input longint act, input longint exp);
    nchecks++;
    if (act != exp) begin
      nerrs++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Checks one router's outputs against its model, then advances the model
  // to the state the next rising edge should produce.
  task automatic model(ref int q[$], input int cap, input string nm,
                       input int outst, input logic f, input logic e,
                       input logic rv_o, input logic rr_o, input logic sr_o,
                       input logic [3:0] sv_o, input logic [31:0] sd_o);
    int sz, head;
    bit full_e, empty_e, srdy_e;
    logic [3:0] sv_e;
    sz      = q.size();
    full_e  = (sz == cap);
    empty_e = (sz == 0);
    head    = empty_e ? 0 : q[0];
    srdy_e  = !empty_e && rsp_ready[head];
    sv_e    = (rsp_valid && !empty_e) ? (4'b0001 << head) : 4'b0000;
    chk({nm, " outstanding"}, outst, sz);
    chk({nm, " full"}, f, full_e);
    chk({nm, " empty"}, e, empty_e);
    chk({nm, " req_valid_o"}, rv_o, req_valid && !full_e);
    chk({nm, " req_ready_o"}, rr_o, req_ready && !full_e);
    chk({nm, " rsp_ready_o"}, sr_o, srdy_e);
    chk({nm, " rsp_valid_o"}, sv_o, sv_e);
    chk({nm, " rsp_data_o"}, sd_o, rsp_data);
    if (rst) begin
      q.delete();
    end else begin
      if (rsp_valid && srdy_e) begin
        void'(q.pop_front());
        npops++;
      end
      if (req_valid && req_ready && !full_e) q.push_back(int'(req_idx));
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      model(q8, 8, "d8", int'(if8.outstanding_o), if8.full_o, if8.empty_o,
            if8.req_valid_o, if8.req_ready_o, if8.rsp_ready_o,
            if8.rsp_valid_o, if8.rsp_data_o);
      model(q5, 5, "d5", int'(if5.outstanding_o), if5.full_o, if5.empty_o,
            if5.req_valid_o, if5.req_ready_o, if5.rsp_ready_o,
            if5.rsp_valid_o, if5.rsp_data_o);
    end
    if (rst) model_ok = 1'b1;
  end

  task automatic drive(input logic rv, input int idx, input logic rr,
                       input logic sv, input logic [31:0] sd,
                       input logic [3:0] srdy, input logic rs);
    req_valid = rv;
    req_idx   = 2'(idx);
    req_ready = rr;
    rsp_valid = sv;
    rsp_data  = sd;
    rsp_ready = srdy;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++)
      drive(1'b0, 0, 1'b1, 1'b1, $urandom, 4'hf, 1'b0);
  endtask

  task automatic rnd(input int n, input int p_req, input int p_rsp,
                     input int p_rdy, input int p_rst);
    logic [3:0] srdy;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++)
        srdy[b] = ($urandom_range(0, 99) < p_rdy);
      drive($urandom_range(0, 99) < p_req, $urandom_range(0, 3),
            $urandom_range(0, 99) < 80, $urandom_range(0, 99) < p_rsp,
            $urandom, srdy, $urandom_range(0, 999) < p_rst);
    end
  endtask

  initial begin
    drive(1'b0, 0, 1'b0, 1'b1, 32'h0, 4'hf, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b1, 32'h1, 4'hf, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b1, 32'h2, 4'hf, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b0, 32'h0, 4'hf, 1'b0);
    // in-order routing of 2,0,3
    drive(1'b1, 2, 1'b1, 1'b0, 32'h0, 4'hf, 1'b0);
    drive(1'b1, 0, 1'b1, 1'b0, 32'h0, 4'hf, 1'b0);
    drive(1'b1, 3, 1'b1, 1'b0, 32'h0, 4'hf, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b1, 32'hd0, 4'hf, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b1, 32'hd1, 4'hf, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b1, 32'hd2, 4'hf, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0, 32'h0, 4'hf, 1'b0);
    // fill to capacity, then response and request together
    for (int i = 0; i < 9; i++)
      drive(1'b1, i % 4, 1'b1, 1'b0, 32'h0, 4'hf, 1'b0);
    drive(1'b1, 1, 1'b1, 1'b1, 32'h55, 4'hf, 1'b0);
    drive(1'b1, 2, 1'b1, 1'b0, 32'h0, 4'hf, 1'b0);
    drain();
    // push into empty with a response already waiting
    drive(1'b1, 1, 1'b1, 1'b1, 32'h77, 4'hf, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b1, 32'h78, 4'hf, 1'b0);
    drain();
    // head input 3 backpressured
    drive(1'b1, 3, 1'b1, 1'b0, 32'h0, 4'hf, 1'b0);
    drive(1'b1, 0, 1'b1, 1'b0, 32'h0, 4'hf, 1'b0);
    for (int i = 0; i < 5; i++)
      drive(1'b0, 0, 1'b1, 1'b1, 32'h33, 4'b0111, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b1, 32'h34, 4'hf, 1'b0);
    drain();
    // interleaved wrap, then reset with 3 outstanding
    for (int i = 0; i < 12; i++)
      drive(1'b1, i % 4, 1'b1, i % 3 != 0, 32'(i), 4'hf, 1'b0);
    drain();
    for (int i = 0; i < 3; i++)
      drive(1'b1, i, 1'b1, 1'b0, 32'h0, 4'hf, 1'b0);
    drive(1'b1, 3, 1'b1, 1'b1, 32'h99, 4'hf, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b1, 32'h9a, 4'hf, 1'b0);
    rnd(600, 70, 40, 70, 5);
    rnd(600, 40, 80, 90, 5);
    rnd(600, 60, 60, 30, 3);
    drain();
    @(negedge clk);
    if (npops < 50) begin
      nerrs++;
      $display("FAIL pop_activity: got %0d pops expected at least 50", npops);
    end
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end
endmodule
